// File: rtl/life_pkg.sv
`default_nettype none
// ============================================================================
// Module   : life_pkg
// Desc     : Shared encodings for the Game of Life sequencing controller.
// Revision : 1.0
// ============================================================================
package life_pkg;

    localparam int CELLS_7X7 = 49;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_PROGRAM = 2'b01,
        ST_RUN     = 2'b10,
        ST_PAUSE   = 2'b11
    } mode_t;

    typedef enum logic [1:0] {
        S_NONE = 2'd0,
        S0     = 2'd1,
        S1     = 2'd2,
        S2     = 2'd3
    } phase_t;

    typedef enum logic [1:0] {
        SEQ_PROG  = 2'd0,
        SEQ_GEN   = 2'd1,
        SEQ_CLEAR = 2'd2
    } seq_t;

    // Field order doubles as priority order, highest first.
    typedef struct packed {
        logic clr;
        logic pause;
        logic start;
        logic b1;
        logic b0;
    } btn_req_t;

endpackage
`default_nettype wire

// File: rtl/life_debounce.sv
`default_nettype none
// ============================================================================
// Module   : life_debounce
// Desc     : 2-flop synchronizer, stable-sample counter, one-cycle press pulse.
// Revision : 1.0
// ============================================================================
module life_debounce #(
    parameter int DEB_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic i_raw,
    output logic o_press
);

    localparam int CW = $clog2(DEB_CYCLES + 1);

    logic [1:0]    r_sync;
    logic          r_level;
    logic [CW-1:0] r_cnt;
    logic          r_press;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync  <= '0;
            r_level <= 1'b0;
            r_cnt   <= '0;
            r_press <= 1'b0;
        end else begin
            r_sync  <= {r_sync[0], i_raw};
            r_press <= 1'b0;
            if (r_sync[1] == r_level) begin
                r_cnt <= '0;
            end else if (r_cnt == CW'(DEB_CYCLES - 1)) begin
                r_level <= r_sync[1];
                r_cnt   <= '0;
                r_press <= r_sync[1];
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign o_press = r_press;

endmodule
`default_nettype wire

// File: rtl/life_controller.sv
`default_nettype none
// ============================================================================
// Module   : life_controller
// Desc     : Mode FSM, strobe sequencer, generation timer and still-life detect.
// Revision : 1.0
// ============================================================================
module life_controller
    import life_pkg::*;
#(
    parameter int CELLS      = CELLS_7X7,
    parameter int DEB_CYCLES = 16,
    parameter int GEN_PERIOD = 1000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_btn_start_raw,
    input  logic             i_btn_pause_raw,
    input  logic             i_btn_clear_raw,
    input  logic             i_btn0_raw,
    input  logic             i_btn1_raw,
    input  logic [CELLS-1:0] i_grid,
    output logic [1:0]       o_state,
    output logic             o_btn0,
    output logic             o_btn1,
    output logic             o_clka,
    output logic             o_clkb,
    output logic             o_stop,
    output logic [5:0]       o_prog_count,
    output logic             o_prog_full,
    output logic [15:0]      o_gen_count,
    output logic             o_stable,
    output logic             o_extinct
);

    localparam int TW = $clog2(GEN_PERIOD);

    logic [4:0] w_raw;
    logic [4:0] w_press_v;
    btn_req_t   w_press, w_req, w_appl, w_cand, w_act;
    logic       w_gen;

    mode_t            r_mode;
    phase_t           r_phase;
    seq_t             r_kind;
    btn_req_t         r_pend;
    logic [TW-1:0]    r_timer;
    logic [CELLS-1:0] r_prev_grid;
    logic             r_clka, r_clkb, r_stop, r_btn0, r_btn1;
    logic             r_prog_full, r_stable, r_extinct;
    logic [5:0]       r_prog_count;
    logic [15:0]      r_gen_count;

    assign w_raw = {i_btn_clear_raw, i_btn_pause_raw, i_btn_start_raw, i_btn1_raw, i_btn0_raw};

    generate
        for (genvar gi = 0; gi < 5; gi++) begin : g_deb
            life_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
                .clk     (clk),
                .rst     (rst),
                .i_raw   (w_raw[gi]),
                .o_press (w_press_v[gi])
            );
        end
    endgenerate

    assign w_press = w_press_v;

    // Requests not applicable in the current mode are dropped at the next free cycle.
    always_comb begin
        w_req        = r_pend | w_press;
        w_appl       = '0;
        w_appl.clr   = 1'b1;
        w_appl.pause = (r_mode == ST_RUN) || (r_mode == ST_PAUSE);
        w_appl.start = (r_mode == ST_IDLE) || (r_mode == ST_PROGRAM);
        w_appl.b0    = (r_mode == ST_PROGRAM) && !r_prog_full && !(w_req.b0 && w_req.b1);
        w_appl.b1    = w_appl.b0;
        w_cand       = w_req & w_appl;
        w_act        = '0;
        if (w_cand.clr)        w_act.clr   = 1'b1;
        else if (w_cand.pause) w_act.pause = 1'b1;
        else if (w_cand.start) w_act.start = 1'b1;
        else if (w_cand.b1)    w_act.b1    = 1'b1;
        else if (w_cand.b0)    w_act.b0    = 1'b1;
        w_gen = (r_mode == ST_RUN) && (r_timer == TW'(GEN_PERIOD - 1)) && (w_act == '0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mode       <= ST_IDLE;
            r_phase      <= S_NONE;
            r_kind       <= SEQ_PROG;
            r_pend       <= '0;
            r_timer      <= '0;
            r_prev_grid  <= '0;
            r_clka       <= 1'b0;
            r_clkb       <= 1'b0;
            r_stop       <= 1'b0;
            r_btn0       <= 1'b0;
            r_btn1       <= 1'b0;
            r_prog_full  <= 1'b0;
            r_stable     <= 1'b0;
            r_extinct    <= 1'b0;
            r_prog_count <= '0;
            r_gen_count  <= '0;
        end else begin
            if (r_mode == ST_RUN)
                r_timer <= (r_timer == TW'(GEN_PERIOD - 1)) ? '0 : r_timer + 1'b1;

            if (r_phase == S_NONE) r_pend <= w_cand & ~w_act;
            else                   r_pend <= r_pend | w_press;

            case (r_phase)
                S0: begin
                    r_clka  <= 1'b0;
                    r_clkb  <= 1'b1;
                    r_btn0  <= 1'b0;
                    r_btn1  <= 1'b0;
                    r_stop  <= (r_kind == SEQ_CLEAR);
                    r_phase <= S1;
                end
                S1: begin
                    r_clkb  <= 1'b0;
                    r_stop  <= 1'b0;
                    r_phase <= S2;
                end
                S2: begin
                    // Non-generation sequences use S2 purely as the inter-sequence gap.
                    r_phase <= S_NONE;
                    if (r_kind == SEQ_GEN) begin
                        if (r_gen_count != 16'hFFFF) r_gen_count <= r_gen_count + 1'b1;
                        if (i_grid == '0) begin
                            r_extinct <= 1'b1;
                            r_mode    <= ST_PAUSE;
                        end else if (i_grid == r_prev_grid) begin
                            r_stable <= 1'b1;
                            r_mode   <= ST_PAUSE;
                        end
                        r_prev_grid <= i_grid;
                    end
                end
                default: begin
                    if (w_act.clr) begin
                        r_mode       <= ST_IDLE;
                        r_phase      <= S0;
                        r_clka       <= 1'b1;
                        r_kind       <= SEQ_CLEAR;
                        r_prog_count <= '0;
                        r_prog_full  <= 1'b0;
                        r_gen_count  <= '0;
                        r_prev_grid  <= '0;
                        r_stable     <= 1'b0;
                        r_extinct    <= 1'b0;
                        r_timer      <= '0;
                    end else if (w_act.pause) begin
                        if (r_mode == ST_RUN) begin
                            r_mode <= ST_PAUSE;
                        end else begin
                            r_mode    <= ST_RUN;
                            r_stable  <= 1'b0;
                            r_extinct <= 1'b0;
                            r_timer   <= '0;
                        end
                    end else if (w_act.start) begin
                        if (r_mode == ST_IDLE) begin
                            r_mode       <= ST_PROGRAM;
                            r_prog_count <= '0;
                            r_prog_full  <= 1'b0;
                            r_phase      <= S0;
                            r_clka       <= 1'b1;
                            r_kind       <= SEQ_PROG;
                        end else begin
                            r_mode      <= ST_RUN;
                            r_timer     <= '0;
                            r_gen_count <= '0;
                        end
                    end else if (w_act.b1 || w_act.b0) begin
                        r_phase      <= S0;
                        r_clka       <= 1'b1;
                        r_kind       <= SEQ_PROG;
                        r_btn1       <= w_act.b1;
                        r_btn0       <= w_act.b0;
                        r_prog_count <= r_prog_count + 1'b1;
                        r_prog_full  <= (r_prog_count == 6'(CELLS - 1));
                    end else if (w_gen) begin
                        r_phase <= S0;
                        r_clka  <= 1'b1;
                        r_kind  <= SEQ_GEN;
                    end
                end
            endcase
        end
    end

    assign o_state      = r_mode;
    assign o_btn0       = r_btn0;
    assign o_btn1       = r_btn1;
    assign o_clka       = r_clka;
    assign o_clkb       = r_clkb;
    assign o_stop       = r_stop;
    assign o_prog_count = r_prog_count;
    assign o_prog_full  = r_prog_full;
    assign o_gen_count  = r_gen_count;
    assign o_stable     = r_stable;
    assign o_extinct    = r_extinct;

endmodule
`default_nettype wire

// File: tb/tb_life_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_life_controller
// Desc     : Self-checking bench for life_controller (tables, sequences, random grids).
// Revision : 1.0
// ============================================================================
module tb_life_controller;

    localparam int DEB   = 4;
    localparam int GP    = 8;
    localparam int CELLS = 49;

    localparam logic [48:0] BLINK_H = (49'd1 << 23) | (49'd1 << 24) | (49'd1 << 25);
    localparam logic [48:0] BLINK_V = (49'd1 << 16) | (49'd1 << 24) | (49'd1 << 32);
    localparam logic [48:0] BLOCK   = (49'd1 << 8) | (49'd1 << 9) | (49'd1 << 15) | (49'd1 << 16);

    logic        clk = 1'b0;
    logic        rst;
    logic        r_start, r_pause, r_clear, r_b0, r_b1;
    logic [48:0] i_grid;
    logic [1:0]  o_state;
    logic        o_btn0, o_btn1, o_clka, o_clkb, o_stop, o_prog_full, o_stable, o_extinct;
    logic [5:0]  o_prog_count;
    logic [15:0] o_gen_count;

    life_controller #(.CELLS(CELLS), .DEB_CYCLES(DEB), .GEN_PERIOD(GP)) dut (
        .clk(clk), .rst(rst),
        .i_btn_start_raw(r_start), .i_btn_pause_raw(r_pause), .i_btn_clear_raw(r_clear),
        .i_btn0_raw(r_b0), .i_btn1_raw(r_b1), .i_grid(i_grid),
        .o_state(o_state), .o_btn0(o_btn0), .o_btn1(o_btn1), .o_clka(o_clka), .o_clkb(o_clkb),
        .o_stop(o_stop), .o_prog_count(o_prog_count), .o_prog_full(o_prog_full),
        .o_gen_count(o_gen_count), .o_stable(o_stable), .o_extinct(o_extinct)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Strobe observer; also feeds the grid back the way a datapath would.
    int          n_clka = 0, overlap = 0, orphan_stop = 0, cyc = 0;
    bit          last_b1, last_b0, blink_phase;
    int          clka_cyc[$];
    int          clkb_state_q[$];
    bit          clkb_stop_q[$];
    int          grid_mode = 0;
    logic [48:0] grid_list[$];

    always @(negedge clk) begin
        cyc++;
        if (o_clka) begin
            n_clka++;
            last_b1 = o_btn1;
            last_b0 = o_btn0;
            clka_cyc.push_back(cyc);
            if (grid_mode == 1) begin
                blink_phase = !blink_phase;
                i_grid = blink_phase ? BLINK_H : BLINK_V;
            end else if (grid_mode == 2 && grid_list.size() > 0) begin
                i_grid = grid_list.pop_front();
            end
        end
        if (o_clka && o_clkb) overlap++;
        if (o_stop && !o_clkb) orphan_stop++;
        if (o_clkb) begin
            clkb_state_q.push_back(int'(o_state));
            clkb_stop_q.push_back(o_stop);
        end
    end

    task automatic set_raw(input int b, input logic v);
        case (b)
            0: r_start = v;
            1: r_pause = v;
            2: r_clear = v;
            3: r_b0 = v;
            4: r_b1 = v;
            default: begin r_b0 = v; r_b1 = v; end
        endcase
    endtask

    // 0 start, 1 pause, 2 clear, 3 btn0, 4 btn1, 5 btn0+btn1 together
    task automatic press(input int b);
        @(negedge clk);
        set_raw(b, 1'b1);
        repeat (DEB + 6) @(negedge clk);
        set_raw(b, 1'b0);
        repeat (DEB + 6) @(negedge clk);
    endtask

    task automatic wait_state(input string name, input int st, input int budget);
        int n = 0;
        while (int'(o_state) != st && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(name, o_state, st);
    endtask

    task automatic wait_clka(input string name);
        int n = 0;
        while (!o_clka && n < 100) begin
            @(negedge clk);
            n++;
        end
        check(name, o_clka, 1);
    endtask

    typedef struct {
        int         btn;
        int         exp_clka;
        bit         exp_b1;
        bit         exp_b0;
        logic [1:0] exp_state;
        int         exp_prog;
    } vec_t;

    vec_t tbl[9];

    initial begin
        int n0, nb, g0, exp_n, b;
        bit exp_st, exp_ex;
        logic [48:0] prev, g;
        logic [48:0] lst[12];

        rst = 1'b1;
        {r_start, r_pause, r_clear, r_b0, r_b1} = '0;
        i_grid = '0;
        repeat (3) @(negedge clk);
        check("rst_state", o_state, 0);
        check("rst_strobes", {o_clka, o_clkb, o_stop, o_btn0, o_btn1}, 0);
        check("rst_prog", o_prog_count, 0);
        check("rst_gen", o_gen_count, 0);
        check("rst_flags", {o_stable, o_extinct, o_prog_full}, 0);
        rst = 1'b0;

        tbl = '{'{0, 1, 0, 0, 2'b01, 0}, '{4, 1, 1, 0, 2'b01, 1}, '{3, 1, 0, 1, 2'b01, 2},
                '{4, 1, 1, 0, 2'b01, 3}, '{1, 0, 0, 0, 2'b01, 3}, '{5, 0, 0, 0, 2'b01, 3},
                '{2, 1, 0, 0, 2'b00, 0}, '{0, 1, 0, 0, 2'b01, 0}, '{3, 1, 0, 1, 2'b01, 1}};
        for (int i = 0; i < 9; i++) begin
            n0 = n_clka;
            press(tbl[i].btn);
            check($sformatf("tbl%0d_clka", i), n_clka - n0, tbl[i].exp_clka);
            if (tbl[i].exp_clka > 0) begin
                check($sformatf("tbl%0d_btn1", i), last_b1, tbl[i].exp_b1);
                check($sformatf("tbl%0d_btn0", i), last_b0, tbl[i].exp_b0);
                check($sformatf("tbl%0d_stop", i), clkb_stop_q[$], (tbl[i].btn == 2));
            end
            check($sformatf("tbl%0d_state", i), o_state, tbl[i].exp_state);
            check($sformatf("tbl%0d_prog", i), o_prog_count, tbl[i].exp_prog);
        end

        // Fill the grid with 50 random data presses
        press(2);
        press(0);
        for (int k = 0; k < 50; k++) begin
            b = int'($urandom_range(3, 4));
            n0 = n_clka;
            press(b);
            if (k < CELLS) begin
                check($sformatf("fill%0d_clka", k), n_clka - n0, 1);
                check($sformatf("fill%0d_bit", k), {last_b1, last_b0}, (b == 4) ? 2 : 1);
                check($sformatf("fill%0d_prog", k), o_prog_count, k + 1);
                check($sformatf("fill%0d_full", k), o_prog_full, (k == CELLS - 1));
            end else begin
                check("fill_over_clka", n_clka - n0, 0);
                check("fill_over_prog", o_prog_count, CELLS);
            end
        end
        check("fill_state", o_state, 1);

        // Blinker run: fixed period, never stable
        grid_mode = 1;
        nb = n_clka;
        press(0);
        n0 = clka_cyc.size();
        begin
            int n = 0;
            while (clka_cyc.size() < n0 + 6 && n < 200) begin
                @(negedge clk);
                n++;
            end
        end
        check("blink_gens", clka_cyc.size() >= n0 + 6, 1);
        for (int j = 0; j < 5; j++)
            check($sformatf("blink_period%0d", j), clka_cyc[n0 + j + 1] - clka_cyc[n0 + j], GP);
        repeat (4) @(negedge clk);
        check("blink_gen_count", o_gen_count, n_clka - nb);
        check("blink_stable", o_stable, 0);
        check("blink_state", o_state, 2);

        // Pause freezes the timer; start is ignored while paused
        press(1);
        check("pause_state", o_state, 3);
        g0 = int'(o_gen_count);
        n0 = n_clka;
        repeat (30) @(negedge clk);
        press(0);
        check("pause_no_clka", n_clka - n0, 0);
        check("pause_gen_frozen", o_gen_count, g0);
        check("pause_start_ignored", o_state, 3);

        // Still block: second compare auto-pauses
        grid_mode = 0;
        i_grid = BLOCK;
        press(1);
        wait_state("block_pause", 3, 100);
        check("block_stable", o_stable, 1);
        check("block_extinct", o_extinct, 0);
        check("block_gens", o_gen_count, g0 + 2);
        grid_mode = 1;
        press(1);
        check("resume_state", o_state, 2);
        check("resume_stable", o_stable, 0);

        // Clear landing during S0 of a generation
        wait_clka("clr_sync_clka");
        repeat (2) @(negedge clk);
        r_clear = 1'b1;
        repeat (DEB + 6) @(negedge clk);
        r_clear = 1'b0;
        repeat (DEB + 6) @(negedge clk);
        grid_mode = 0;
        check("clr_gen_first_stop", clkb_stop_q[clkb_stop_q.size() - 2], 0);
        check("clr_gen_first_state", clkb_state_q[clkb_state_q.size() - 2], 2);
        check("clr_stop", clkb_stop_q[$], 1);
        check("clr_stop_state", clkb_state_q[$], 0);
        check("clr_counts", {o_gen_count, o_prog_count}, 0);
        check("clr_flags", {o_stable, o_extinct}, 0);

        // Random grid sequences vs. a generation-by-generation model
        for (int r = 0; r < 3; r++) begin
            press(0);
            prev = '0;
            for (int i = 0; i < 12; i++) begin
                b = int'($urandom_range(0, 7));
                if (i == 11)                lst[i] = lst[10];
                else if (i > 0 && b < 2)    lst[i] = lst[i - 1];
                else if (b == 2)            lst[i] = '0;
                else                        lst[i] = 49'({$urandom(), $urandom()});
            end
            exp_n = 0; exp_st = 1'b0; exp_ex = 1'b0;
            for (int i = 0; i < 12; i++) begin
                if (!exp_st && !exp_ex) begin
                    g = lst[i];
                    exp_n++;
                    if (g == '0)        exp_ex = 1'b1;
                    else if (g == prev) exp_st = 1'b1;
                    prev = g;
                end
            end
            grid_list.delete();
            for (int i = 0; i < 12; i++) grid_list.push_back(lst[i]);
            grid_mode = 2;
            press(0);
            wait_state($sformatf("rnd%0d_pause", r), 3, 300);
            check($sformatf("rnd%0d_gens", r), o_gen_count, exp_n);
            check($sformatf("rnd%0d_stable", r), o_stable, exp_st);
            check($sformatf("rnd%0d_extinct", r), o_extinct, exp_ex);
            grid_mode = 0;
            press(2);
        end

        // Reset during S1 aborts the sequence
        grid_mode = 1;
        press(0);
        press(0);
        wait_clka("rst_sync_clka");
        @(negedge clk);
        check("rst_pre_clkb", o_clkb, 1);
        #1 rst = 1'b1;
        #1;
        check("rst_async_clkb", {o_clka, o_clkb, o_stop, o_btn0, o_btn1}, 0);
        check("rst_async_state", o_state, 0);
        check("rst_async_counts", {o_gen_count, o_prog_count}, 0);
        @(negedge clk);
        rst = 1'b0;
        n0 = n_clka;
        repeat (30) @(negedge clk);
        check("rst_no_strobes", n_clka - n0, 0);

        check("strobe_overlap", overlap, 0);
        check("stop_outside_clkb", orphan_stop, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/life_controller.md
# life_controller

Sequencing controller for the 7x7 Game of Life datapath. Debounces the user buttons, drives the datapath's `state` code, and generates the `clka` compute and `clkb` commit strobes. Also produces the `btn0`/`btn1` programming bits and the `stop` clear. Runs a periodic generation timer in RUN and auto-pauses when the grid reaches a still life or dies out.

## Interface
- `CELLS`, 49, cells per grid; programming-bit limit and `grid` width.
- `DEB_CYCLES`, 16, consecutive stable samples required to accept a button level change.
- `GEN_PERIOD`, 1000, `clk` cycles between generation starts in RUN; minimum 4.
- `clk` in 1: single system clock, all logic on rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `btn_start_raw`, `btn_pause_raw`, `btn_clear_raw`, `btn0_raw`, `btn1_raw` in 1 each: asynchronous push buttons, active-high.
- `grid` in `CELLS`: current datapath grid, read back for stability detection.
- `state` out 2: datapath mode. IDLE=00, PROGRAM=01, RUN=10, PAUSE=11.
- `btn0`, `btn1` out 1 each: programming bit (0 or 1), valid while `clka`=1.
- `clka` out 1: one-cycle compute strobe; the datapath acts on its falling edge.
- `clkb` out 1: one-cycle commit strobe; the datapath acts on its falling edge.
- `stop` out 1: high only during the `clkb` pulse of a clear sequence.
- `prog_count` out 6: number of cells programmed, 0..`CELLS`.
- `prog_full` out 1: `prog_count`==`CELLS`.
- `gen_count` out 16: generations committed since the last clear; saturates at 16'hFFFF.
- `stable` out 1: set on auto-pause; cleared on resume or clear.
- `extinct` out 1: grid committed all-zero; same set/clear rules as `stable`.

## Operation
- Each raw button passes through a 2-flop synchronizer and a debouncer, which emits a one-cycle `press` pulse on each accepted 0->1 transition.
- Press priority, highest first: clear > pause > start > data buttons.
- A `press` arriving while a strobe sequence is in flight is held in a one-deep pending flag per button.
  - It is acted on in the first free cycle.
  - A second press of the same button while pending is dropped.
- Strobe sequence:
  - cycle S0: `clka`=1.
  - cycle S1: `clkb`=1.
  - cycle S2 (RUN generations only): compare.
  - `state` is held constant from S0 through S1.
- IDLE: a start press loads `prog_count`=0, sets `state`=PROGRAM, and issues one sequence with `btn0`=`btn1`=0. In PROGRAM, an unpressed cell stays 0.
- PROGRAM:
  - A `btn0` or `btn1` press with `prog_count`<`CELLS` issues a sequence with that bit driven during S0, then increments `prog_count`.
  - A press when `prog_full` is ignored.
  - Simultaneous `btn0` and `btn1` presses in the same cycle are both ignored.
  - A start press sets `state`=RUN, clears the timer, and loads `gen_count`=0.
- RUN: the timer counts 0..`GEN_PERIOD`-1. At terminal count it issues a generation sequence.
  - At S2:
    - `gen_count`++.
    - If `grid`==0: `extinct`=1 and `state`=PAUSE.
    - Else if `grid`==`prev_grid`: `stable`=1 and `state`=PAUSE.
    - `prev_grid` is then loaded with `grid`.
  - A pause press moves to PAUSE after any in-flight S2 completes.
- PAUSE: the timer is frozen.
  - A pause press clears `stable`/`extinct`, sets `state`=RUN, and restarts the timer at 0.
  - A start press is ignored.
- Clear from any state:
  - Wait for any in-flight sequence to finish.
  - Set `state`=IDLE and issue a sequence with `stop`=1 during S1.
  - Clear `prog_count`, `gen_count`, `prev_grid`, `stable`, `extinct` and the timer.
- Reset mid-sequence aborts immediately; no strobe is completed.

## Timing
- Reset values: `state`=00; `clka`=`clkb`=`stop`=`btn0`=`btn1`=0; `prog_count`=0; `gen_count`=0; `stable`=`extinct`=0; `prev_grid`=0.
- Raw press to `press` pulse: 2 + `DEB_CYCLES` cycles.
- `press` to `clka`: 1 cycle when idle.
- `clka` and `clkb` are never high together and are never high on consecutive sequences without a gap. This gives a minimum 1 idle cycle after S1 (PROGRAM/clear) or after S2 (RUN).
- Generation period is exactly `GEN_PERIOD` cycles, measured from `clka` to `clka`.
- `grid` is sampled at S2, one cycle after `clkb` falls.
- All outputs are registered.

## Structure
- Package `life_pkg`:
  - state encodings `ST_IDLE`, `ST_PROGRAM`, `ST_RUN`, `ST_PAUSE`;
  - `CELLS_7X7`=49;
  - the strobe-phase enum (S_NONE, S0, S1, S2).
- Sub-module `life_debounce`: synchronizer, stable-sample counter and press pulse. Instantiated 5 times.
- Top level: mode FSM, strobe sequencer, generation timer, counters and comparator.

## Test plan
- Reset, start, then presses btn1, btn0, btn1 -> three sequences with `btn1`=1,0,1 at `clka`; `prog_count`=3; `state`=01 throughout.
- 50 data presses in PROGRAM -> `prog_full`=1 after 49; 50th yields no `clka`; `prog_count` stays 49.
- Program a blinker (cells 23,24,25), start, `GEN_PERIOD`=8 -> `clka` every 8 cycles, `gen_count` increments, `stable` never asserts.
- Program a 2x2 block at cells 8,9,15,16, run -> second compare sets `stable`=1 and `state`=11; pause press resumes with `stable`=0.
- Clear pressed during S0 of a generation -> the sequence completes, then `state`=00 with `stop`=1 coincident with `clkb`; all counters 0.
- `rst` asserted during S1 -> `clkb` drops asynchronously, all outputs at reset values, no further strobes.
